// File: rtl/xif_coproc_pkg.sv
// Shared types and constants for the CV-X-IF coprocessor issue responder.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package xif_coproc_pkg;

  localparam int PKG_XLEN     = 32;
  localparam int PKG_ID_WIDTH = 4;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    F3_ADD = 3'b000,
    F3_SLL = 3'b001,
    F3_XOR = 3'b100
  } funct3_e;

  // One outstanding instruction: destination, computed value and its commit fate
  typedef struct packed {
    logic [PKG_ID_WIDTH-1:0] id;
    logic [4:0]              rd;
    logic [PKG_XLEN-1:0]     data;
    logic                    committed;
    logic                    killed;
  } rob_entry_t;

  // True for the custom-0 ALU encodings this coprocessor executes
  function automatic logic is_custom_alu(input logic [31:0] instr);
    logic f3_ok;
    case (funct3_e'(instr[14:12]))
      F3_ADD, F3_SLL, F3_XOR: f3_ok = 1'b1;
      default:                f3_ok = 1'b0;
    endcase
    return (instr[6:0] == OPCODE_CUSTOM0) && (instr[31:25] == 7'd0) && f3_ok;
  endfunction

endpackage

// File: rtl/xif_coproc_issue_responder_if.sv
// Issue/commit/result bundle between the CPU (master) and the coprocessor (slave).
// Latency: n/a (wiring only).
// Backpressure: issue via issue_ready_o, result via result_ready_i.
interface xif_coproc_issue_responder_if #(
  parameter int XLEN       = 32,
  parameter int X_NUM_RS   = 2,
  parameter int X_ID_WIDTH = 4
);
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [31:0]              issue_instr_i;
  logic [1:0]               issue_mode_i;
  logic [X_ID_WIDTH-1:0]    issue_id_i;
  logic [X_NUM_RS*XLEN-1:0] issue_rs_i;
  logic [X_NUM_RS-1:0]      issue_rs_valid_i;
  logic                     issue_accept_o;
  logic                     issue_writeback_o;
  logic                     commit_valid_i;
  logic [X_ID_WIDTH-1:0]    commit_id_i;
  logic                     commit_kill_i;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [X_ID_WIDTH-1:0]    result_id_o;
  logic [XLEN-1:0]          result_data_o;
  logic [4:0]               result_rd_o;
  logic                     result_we_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_mode_i, issue_id_i, issue_rs_i,
           issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
           result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_mode_i, issue_id_i, issue_rs_i,
           issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
           result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/xif_coproc_rob.sv
// In-order buffer of executed instructions awaiting commit/kill, with commit-by-ID search.
// Latency: push/commit/pop take effect on the next clock edge; head is a registered entry.
// Backpressure: caller must not push when count_o == DEPTH; pop only when head_vld_o.
module xif_coproc_rob
  import xif_coproc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  rob_entry_t                push_entry_i,
  input  logic                      commit_valid_i,
  input  logic [PKG_ID_WIDTH-1:0]   commit_id_i,
  input  logic                      commit_kill_i,
  input  logic                      pop_i,
  output logic                      head_vld_o,
  output rob_entry_t                head_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rob_entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [PW-1:0]        head_q;
  logic [PW-1:0]        tail_q;
  logic [CW-1:0]        count_q;

  logic                 hit;
  logic [PW-1:0]        hit_idx;
  logic [PW-1:0]        idx;
  logic                 push_hit;
  rob_entry_t           new_entry;

  // Oldest-first search for the commit target among the stored entries
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (!hit && vld_q[idx] && (mem_q[idx].id == commit_id_i)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  // A commit naming the instruction being pushed this cycle lands on the new entry
  always_comb begin
    push_hit            = commit_valid_i && !hit && (push_entry_i.id == commit_id_i);
    new_entry           = push_entry_i;
    new_entry.committed = push_hit && !commit_kill_i;
    new_entry.killed    = push_hit && commit_kill_i;
  end

  // Storage, pointer and occupancy update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= new_entry;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      if (commit_valid_i && hit) begin
        if (commit_kill_i) mem_q[hit_idx].killed    <= 1'b1;
        else               mem_q[hit_idx].committed <= 1'b1;
      end
      if (pop_i) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_vld_o = vld_q[head_q];
  assign head_o     = mem_q[head_q];
  assign count_o    = count_q;

endmodule

// File: rtl/xif_coproc_issue_responder.sv
// Coprocessor responder: decodes/executes custom-0 ALU ops, holds them in order until commit.
// Latency: accept/reject same cycle; result presented >=1 cycle after the head is committed.
// Backpressure: accepted ops stall when full or operands invalid; result held until result_ready_i.
module xif_coproc_issue_responder
  import xif_coproc_pkg::*;
#(
  parameter int XLEN       = PKG_XLEN,
  parameter int X_NUM_RS   = 2,
  parameter int X_ID_WIDTH = PKG_ID_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  xif_coproc_issue_responder_if.slave    xif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] rs0;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] alu_res;
  logic            dec_ok;
  logic            push;
  rob_entry_t      push_entry;
  rob_entry_t      head_entry;
  logic            head_vld;
  logic [CW-1:0]   rob_count;
  logic            rob_pop;
  logic            pop_kill;
  logic            load;
  logic            res_fire;
  logic            res_vld_q;
  rob_entry_t      res_q;
  logic            res_we_q;
  logic            unused_bits;

  assign rs0    = xif.issue_rs_i[0 +: XLEN];
  assign rs1    = xif.issue_rs_i[XLEN +: XLEN];
  assign dec_ok = is_custom_alu(xif.issue_instr_i);

  // Custom-0 ALU datapath
  always_comb begin
    alu_res = '0;
    case (funct3_e'(xif.issue_instr_i[14:12]))
      F3_ADD:  alu_res = rs0 + rs1;
      F3_XOR:  alu_res = rs0 ^ rs1;
      F3_SLL:  alu_res = rs0 << rs1[4:0];
      default: alu_res = '0;
    endcase
  end

  // Rejects always handshake; accepts need space and both operands
  assign xif.issue_ready_o     = !dec_ok || ((rob_count < CW'(DEPTH)) &&
                                             xif.issue_rs_valid_i[0] && xif.issue_rs_valid_i[1]);
  assign xif.issue_accept_o    = xif.issue_valid_i && dec_ok;
  assign xif.issue_writeback_o = xif.issue_valid_i && dec_ok;
  assign push                  = xif.issue_valid_i && xif.issue_ready_o && dec_ok;

  assign push_entry = '{id: xif.issue_id_i, rd: xif.issue_instr_i[11:7], data: alu_res,
                        committed: 1'b0, killed: 1'b0};

  // Killed heads drain silently; committed heads move into the result register
  assign pop_kill = !res_vld_q && head_vld && head_entry.killed;
  assign load     = !res_vld_q && head_vld && head_entry.committed && !head_entry.killed;
  assign res_fire = res_vld_q && xif.result_ready_i;
  assign rob_pop  = pop_kill || res_fire;

  xif_coproc_rob #(.DEPTH(DEPTH)) u_rob (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .push_i         (push),
    .push_entry_i   (push_entry),
    .commit_valid_i (xif.commit_valid_i),
    .commit_id_i    (xif.commit_id_i),
    .commit_kill_i  (xif.commit_kill_i),
    .pop_i          (rob_pop),
    .head_vld_o     (head_vld),
    .head_o         (head_entry),
    .count_o        (rob_count)
  );

  // Result register: holds the head copy stable until the CPU takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
      res_we_q  <= 1'b0;
    end else if (res_fire) begin
      res_vld_q <= 1'b0;
    end else if (load) begin
      res_vld_q <= 1'b1;
      res_q     <= head_entry;
      res_we_q  <= (head_entry.rd != 5'd0);
    end
  end

  assign xif.result_valid_o = res_vld_q;
  assign xif.result_id_o    = res_q.id;
  assign xif.result_data_o  = res_q.data;
  assign xif.result_rd_o    = res_q.rd;
  assign xif.result_we_o    = res_we_q;

  assign unused_bits = ^{xif.issue_mode_i, xif.issue_instr_i[24:15], res_q.committed, res_q.killed};

endmodule

// File: tb/tb_xif_coproc_issue_responder.sv
// Directed bench for the coprocessor issue responder: decode, commit/kill, ordering, stall, reset.
// Latency: n/a.
// Backpressure: bench drives result_ready_i, including a multi-cycle hold.
module tb_xif_coproc_issue_responder;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  xif_coproc_issue_responder_if #(.XLEN(32), .X_NUM_RS(2), .X_ID_WIDTH(4)) xif ();

  xif_coproc_issue_responder #(.XLEN(32), .X_NUM_RS(2), .X_ID_WIDTH(4), .DEPTH(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .xif    (xif)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0, 10'b0, f3, rd, 7'b0001011};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv_issue(input logic [31:0] instr, input logic [3:0] id,
                           input logic [31:0] a, input logic [31:0] b);
    xif.issue_valid_i    = 1'b1;
    xif.issue_instr_i    = instr;
    xif.issue_id_i       = id;
    xif.issue_rs_i       = {b, a};
    xif.issue_rs_valid_i = 2'b11;
  endtask

  task automatic drv_commit(input logic [3:0] id, input logic kill);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
  endtask

  task automatic idle();
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b0;
    xif.commit_kill_i  = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc, output logic found, output logic [3:0] id,
                             output logic [31:0] data, output logic [4:0] rd, output logic we);
    found = 1'b0; id = '0; data = '0; rd = '0; we = 1'b0;
    for (int c = 0; c < max_cyc && !found; c++) begin
      #1;
      if (xif.result_valid_o === 1'b1) begin
        found = 1'b1; id = xif.result_id_o; data = xif.result_data_o;
        rd = xif.result_rd_o; we = xif.result_we_o;
      end
      tick();
    end
  endtask

  task automatic watch_quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      #1;
      if (xif.result_valid_o !== 1'b0) seen = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drv_issue(mk(3'b000, 5'd1), 4'd0, 32'd1, 32'd1);
    repeat (3) tick();
    #1;
    n_assert++; if (xif.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", xif.result_valid_o); end
    n_assert++; if (xif.result_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", xif.result_data_o); end
    n_assert++; if ({xif.result_id_o, xif.result_rd_o, xif.result_we_o} !== 10'd0) begin n_fail++; $display("FAIL reset_id_rd_we: got %h want 0", {xif.result_id_o, xif.result_rd_o, xif.result_we_o}); end
    n_assert++; if (xif.issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", xif.issue_ready_o); end
    idle();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_add();
    logic f; logic [3:0] id; logic [31:0] d; logic [4:0] rd; logic we;
    drv_issue(32'h00C5850B, 4'd3, 32'd5, 32'd7);
    #1;
    n_assert++; if ({xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o} !== 3'b111) begin n_fail++; $display("FAIL add_handshake: got %b want 111", {xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o}); end
    tick();
    idle(); drv_commit(4'd3, 1'b0);
    tick();
    idle();
    wait_result(10, f, id, d, rd, we);
    n_assert++; if (f !== 1'b1) begin n_fail++; $display("FAIL add_result_timeout: got found=%b want 1", f); end
    n_assert++; if ({id, d, rd, we} !== {4'd3, 32'd12, 5'd10, 1'b1}) begin n_fail++; $display("FAIL add_result: got id=%0d data=%h rd=%0d we=%b want id=3 data=0000000c rd=10 we=1", id, d, rd, we); end
  endtask

  task automatic test_reject();
    logic seen;
    drv_issue(32'h00000033, 4'd5, 32'd1, 32'd2);
    xif.issue_rs_valid_i = 2'b00;
    #1;
    n_assert++; if ({xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o} !== 3'b100) begin n_fail++; $display("FAIL reject_handshake: got %b want 100", {xif.issue_ready_o, xif.issue_accept_o, xif.issue_writeback_o}); end
    tick();
    idle(); drv_commit(4'd5, 1'b0);
    tick();
    idle();
    watch_quiet(8, seen);
    n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reject_no_result: got seen=%b want 0", seen); end
  endtask

  task automatic test_full();
    logic f; logic seen; logic [3:0] id; logic [31:0] d; logic [4:0] rd; logic we;
    for (int i = 0; i < 4; i++) begin
      drv_issue(mk(3'b000, 5'(i + 1)), 4'(i), 32'h10 * (i + 1), 32'h20);
      #1;
      n_assert++; if ({xif.issue_ready_o, xif.issue_accept_o} !== 2'b11) begin n_fail++; $display("FAIL fill_%0d: got ready/accept=%b want 11", i, {xif.issue_ready_o, xif.issue_accept_o}); end
      tick();
    end
    drv_issue(mk(3'b000, 5'd9), 4'd4, 32'd1, 32'd1);
    #1;
    n_assert++; if ({xif.issue_ready_o, xif.issue_accept_o} !== 2'b01) begin n_fail++; $display("FAIL full_stall: got ready/accept=%b want 01", {xif.issue_ready_o, xif.issue_accept_o}); end
    xif.issue_instr_i = 32'h00000033;
    #1;
    n_assert++; if ({xif.issue_ready_o, xif.issue_accept_o} !== 2'b10) begin n_fail++; $display("FAIL full_reject_ready: got ready/accept=%b want 10", {xif.issue_ready_o, xif.issue_accept_o}); end
    tick();
    idle(); xif.issue_instr_i = mk(3'b000, 5'd9);
    #1;
    n_assert++; if (xif.issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_idle_ready: got %b want 0", xif.issue_ready_o); end
    drv_commit(4'd0, 1'b0);
    tick();
    idle();
    wait_result(10, f, id, d, rd, we);
    n_assert++; if ({f, id, d, rd} !== {1'b1, 4'd0, 32'h30, 5'd1}) begin n_fail++; $display("FAIL full_head_result: got found=%b id=%0d data=%h rd=%0d want found=1 id=0 data=00000030 rd=1", f, id, d, rd); end
    #1;
    n_assert++; if (xif.issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_return: got %b want 1", xif.issue_ready_o); end
    for (int i = 1; i < 4; i++) begin
      drv_commit(4'(i), 1'b1);
      tick();
    end
    idle();
    watch_quiet(6, seen);
    n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL full_kill_drain: got seen=%b want 0", seen); end
  endtask

  task automatic test_kill_commit();
    logic f; logic seen; logic [3:0] id; logic [31:0] d; logic [4:0] rd; logic we;
    drv_issue(mk(3'b100, 5'd5), 4'd1, 32'hFF, 32'h0F);
    tick();
    drv_issue(mk(3'b001, 5'd6), 4'd2, 32'd1, 32'd4);
    tick();
    idle(); drv_commit(4'd1, 1'b1);
    tick();
    drv_commit(4'd2, 1'b0);
    tick();
    idle();
    wait_result(10, f, id, d, rd, we);
    n_assert++; if ({f, id, d, rd, we} !== {1'b1, 4'd2, 32'h10, 5'd6, 1'b1}) begin n_fail++; $display("FAIL kill_commit_result: got found=%b id=%0d data=%h rd=%0d we=%b want found=1 id=2 data=00000010 rd=6 we=1", f, id, d, rd, we); end
    watch_quiet(5, seen);
    n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kill_commit_extra: got seen=%b want 0", seen); end
  endtask

  task automatic test_order();
    logic f; logic seen; logic [3:0] id; logic [31:0] d; logic [4:0] rd; logic we;
    drv_issue(mk(3'b000, 5'd7), 4'd1, 32'd1, 32'd2);
    tick();
    drv_issue(mk(3'b100, 5'd0), 4'd2, 32'hA5, 32'h5A);
    tick();
    idle(); drv_commit(4'd2, 1'b0);
    tick();
    idle();
    watch_quiet(6, seen);
    n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL order_blocked: got seen=%b want 0", seen); end
    drv_commit(4'd1, 1'b0);
    tick();
    idle();
    wait_result(10, f, id, d, rd, we);
    n_assert++; if ({f, id, d, rd, we} !== {1'b1, 4'd1, 32'd3, 5'd7, 1'b1}) begin n_fail++; $display("FAIL order_first: got found=%b id=%0d data=%h rd=%0d we=%b want found=1 id=1 data=00000003 rd=7 we=1", f, id, d, rd, we); end
    wait_result(10, f, id, d, rd, we);
    n_assert++; if ({f, id, d, rd, we} !== {1'b1, 4'd2, 32'hFF, 5'd0, 1'b0}) begin n_fail++; $display("FAIL order_second: got found=%b id=%0d data=%h rd=%0d we=%b want found=1 id=2 data=000000ff rd=0 we=0", f, id, d, rd, we); end
  endtask

  task automatic test_same_cycle_commit();
    logic f; logic [3:0] id; logic [31:0] d; logic [4:0] rd; logic we;
    drv_issue(mk(3'b000, 5'd9), 4'd6, 32'd100, 32'd23);
    drv_commit(4'd6, 1'b0);
    #1;
    n_assert++; if ({xif.issue_ready_o, xif.issue_accept_o} !== 2'b11) begin n_fail++; $display("FAIL same_cycle_handshake: got %b want 11", {xif.issue_ready_o, xif.issue_accept_o}); end
    tick();
    idle();
    wait_result(10, f, id, d, rd, we);
    n_assert++; if ({f, id, d, rd} !== {1'b1, 4'd6, 32'd123, 5'd9}) begin n_fail++; $display("FAIL same_cycle_result: got found=%b id=%0d data=%h rd=%0d want found=1 id=6 data=0000007b rd=9", f, id, d, rd); end
  endtask

  task automatic test_stall_reset();
    logic f; logic seen; logic [3:0] id; logic [31:0] d; logic [4:0] rd; logic we;
    xif.result_ready_i = 1'b0;
    drv_issue(mk(3'b000, 5'd31), 4'd7, 32'hFFFF_FFFF, 32'd2);
    tick();
    idle(); drv_commit(4'd7, 1'b0);
    tick();
    idle();
    wait_result(10, f, id, d, rd, we);
    n_assert++; if ({f, id, d, rd, we} !== {1'b1, 4'd7, 32'd1, 5'd31, 1'b1}) begin n_fail++; $display("FAIL wrap_result: got found=%b id=%0d data=%h rd=%0d we=%b want found=1 id=7 data=00000001 rd=31 we=1", f, id, d, rd, we); end
    for (int c = 0; c < 5; c++) begin
      #1;
      n_assert++; if ({xif.result_valid_o, xif.result_id_o, xif.result_data_o, xif.result_rd_o} !== {1'b1, 4'd7, 32'd1, 5'd31}) begin n_fail++; $display("FAIL hold_%0d: got valid=%b id=%0d data=%h rd=%0d want valid=1 id=7 data=00000001 rd=31", c, xif.result_valid_o, xif.result_id_o, xif.result_data_o, xif.result_rd_o); end
      tick();
    end
    xif.result_ready_i = 1'b1;
    tick();
    xif.result_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_issue(mk(3'b000, 5'(i + 1)), 4'(8 + i), 32'(i), 32'd1);
      tick();
    end
    idle(); drv_commit(4'd8, 1'b0);
    tick();
    idle();
    wait_result(10, f, id, d, rd, we);
    n_assert++; if ({f, id} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL pre_reset_result: got found=%b id=%0d want found=1 id=8", f, id); end
    rst_ni = 1'b0;
    #1;
    n_assert++; if ({xif.result_valid_o, xif.result_data_o, xif.result_id_o} !== 37'd0) begin n_fail++; $display("FAIL async_reset: got valid=%b data=%h id=%0d want all 0", xif.result_valid_o, xif.result_data_o, xif.result_id_o); end
    tick();
    rst_ni = 1'b1;
    xif.result_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_commit(4'(8 + i), 1'b0);
      tick();
    end
    idle();
    watch_quiet(8, seen);
    n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet: got seen=%b want 0", seen); end
  endtask

  initial begin
    rst_ni               = 1'b0;
    xif.issue_valid_i    = 1'b0;
    xif.issue_instr_i    = '0;
    xif.issue_mode_i     = 2'b11;
    xif.issue_id_i       = '0;
    xif.issue_rs_i       = '0;
    xif.issue_rs_valid_i = '0;
    xif.commit_valid_i   = 1'b0;
    xif.commit_id_i      = '0;
    xif.commit_kill_i    = 1'b0;
    xif.result_ready_i   = 1'b1;
    test_reset();
    test_add();
    test_reject();
    test_full();
    test_kill_commit();
    test_order();
    test_same_cycle_commit();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xif_coproc_issue_responder.md
Name: xif_coproc_issue_responder

Overview:
Coprocessor-side responder for the CV-X-IF issue/commit/result path. It is the counterpart of the CPU issue port in the tca_system bench.
- Decodes offered instructions and answers accept/reject in the handshake cycle.
- Executes accepted custom-0 ALU ops and buffers them in order until commit or kill.
- Returns results to the CPU over a valid/ready result channel.

Parameters:
XLEN, 32, register/result data width
X_NUM_RS, 2, number of source operand slots on issue (instructions use rs[0], rs[1])
X_ID_WIDTH, 4, instruction ID width
DEPTH, 4, outstanding-instruction buffer entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  CPU offers instruction
issue_ready_o  out  1  responder takes instruction this cycle
issue_instr_i  in  32  instruction word
issue_mode_i  in  2  privilege mode (ignored, no effect)
issue_id_i  in  X_ID_WIDTH  instruction ID
issue_rs_i  in  X_NUM_RS*XLEN  operands, rs[i] = bits [i*XLEN +: XLEN]
issue_rs_valid_i  in  X_NUM_RS  operand valid flags
issue_accept_o  out  1  instruction accepted (meaningful when valid&&ready)
issue_writeback_o  out  1  accepted instruction writes rd
commit_valid_i  in  1  commit/kill strobe
commit_id_i  in  X_ID_WIDTH  ID being committed/killed
commit_kill_i  in  1  1 = kill, 0 = commit
result_valid_o  out  1  result offered
result_ready_i  in  1  CPU takes result
result_id_o  out  X_ID_WIDTH  result ID
result_data_o  out  XLEN  result value
result_rd_o  out  5  destination register
result_we_o  out  1  write enable (rd != 0)

Behaviour:
Decode, combinational on issue_instr_i:
- Accepted iff opcode[6:0]==7'b0001011 and funct7[31:25]==0.
- funct3 000 = add rs0+rs1 (mod 2^XLEN).
- funct3 100 = xor.
- funct3 001 = sll rs0 << rs1[4:0].
- Any other encoding is rejected.

Issue handshake:
- Rejected encoding: issue_ready_o=1 regardless of buffer state; issue_accept_o=0, issue_writeback_o=0; no state change.
- Accepted encoding: issue_ready_o = (count<DEPTH) && rs_valid[0] && rs_valid[1]. No bypass: a full buffer stalls even if the head pops this cycle.
- issue_accept_o=1 and issue_writeback_o=1 for accepted encodings, zero when !issue_valid_i.
- On valid&&ready&&accept: result computed and pushed at the tail with {id, rd=instr[11:7], data, committed=0, killed=0}. count increments next cycle.

Commit:
- On commit_valid_i, the first valid entry whose id==commit_id_i is marked committed, or killed if commit_kill_i.
- No match means a rejected or unknown ID; ignored silently.
- Commit in the same cycle as the issue handshake of the same ID applies to the newly pushed entry.
- Duplicate outstanding IDs are a protocol violation and are not checked.

Result:
- Head entry is a killed entry: popped in one cycle with no result_valid.
- Head entry committed and not killed: result_valid_o=1 with registered head fields.
- Outputs remain stable until result_ready_i; pop on valid&&ready.
- Next head may be presented the following cycle, not combinationally the same cycle.
- Uncommitted head blocks all younger entries (strict in-order).
- Simultaneous push and pop: count unchanged, pointers wrap modulo DEPTH.

Reset (async, rst_ni=0):
- Pointers, count and valid/committed/killed flags cleared.
- result_valid_o=0, result data/id/rd/we=0.
- issue_ready_o follows the reset-state combinational rule (buffer empty).
- Mid-operation reset discards all outstanding entries; no result is emitted for them.

Decomposition:
Package xif_coproc_pkg:
- OPCODE_CUSTOM0 constant.
- funct3 enum (ADD, XOR, SLL).
- Entry struct {id, rd, data, committed, killed}, parameterised widths via localparams.

Sub-module xif_coproc_rob:
- DEPTH-entry in-order buffer with push, commit-by-ID search, head pop and count.
- The top level holds decode/ALU/handshake logic.

Test Plan:
- Issue 0x00C5850B (add rd=10), id=3, rs0=5, rs1=7; commit id=3 -> accept=1, writeback=1; result id=3, data=12, rd=10, we=1.
- Issue 0x00000033 (OP, not custom-0) -> ready=1, accept=0 same cycle; no result ever; count stays 0.
- Issue 4 accepted ops ids 0..3 without commit -> 5th accepted op sees issue_ready_o=0. A rejected op in the same state still sees ready=1. Commit id 0 and take its result -> ready returns 1 next cycle.
- Ids 1,2 issued (xor 0xFF^0x0F, sll 1<<4); kill 1, commit 2 -> only id=2 result, data=0x10; id 1 produces nothing.
- Commit id 2 before id 1 (both issued) -> no result until id 1 committed; then results in order id1, id2.
- Hold result_ready_i=0 for 5 cycles -> result outputs stable. Assert rst_ni=0 with 3 entries outstanding -> result_valid_o=0 immediately, no results after release.
